// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC-source controller: FSM states, opcode/funct
// values, PC mux selects and the one-hot instruction class.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // PC mux selects; the datapath mux decodes these same values.
  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;
  localparam logic [1:0] PCS_JR  = 2'b11;

  typedef struct packed {
    logic rtype;
    logic jr;
    logic lw;
    logic sw;
    logic addi;
    logic beq;
    logic bne;
    logic j;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational instruction classifier: op/funct to a one-hot class.
module op_classify
  import pc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output op_class_t  o_class
);

  always_comb begin
    o_class = '0;
    case (i_op)
      // jr is an R-type encoding but leaves the normal R-type flow.
      OP_RTYPE: begin
        if (i_funct == FUNCT_JR) o_class.jr = 1'b1;
        else                     o_class.rtype = 1'b1;
      end
      OP_LW:   o_class.lw      = 1'b1;
      OP_SW:   o_class.sw      = 1'b1;
      OP_ADDI: o_class.addi    = 1'b1;
      OP_BEQ:  o_class.beq     = 1'b1;
      OP_BNE:  o_class.bne     = 1'b1;
      OP_J:    o_class.j       = 1'b1;
      default: o_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_source_ctrl.sv
// Multi-cycle control FSM selecting the PC source, with Mealy enables and a
// retired-instruction counter.
module pc_source_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       pc_source,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             reg_we,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic [2:0]       state
);

  state_t          r_state;
  state_t          w_next;
  logic [CNT_W-1:0] r_cnt;
  logic            r_halted;
  op_class_t       w_class;
  logic            w_ready;
  logic [1:0]      w_pcs;
  logic            w_pc_we;
  logic            w_ir_we;
  logic            w_mem_req;
  logic            w_mem_wr;
  logic            w_reg_we;
  logic            w_retire;

  op_classify u_op_classify (
    .i_op    (op),
    .i_funct (funct),
    .o_class (w_class)
  );

  assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    w_next    = r_state;
    w_pcs     = PCS_SEQ;
    w_pc_we   = 1'b0;
    w_ir_we   = 1'b0;
    w_mem_req = 1'b0;
    w_mem_wr  = 1'b0;
    w_reg_we  = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        if (w_ready) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE: w_next = w_class.illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        // Control transfers finish here; everything else moves on.
        if (w_class.beq) begin
          w_pcs    = PCS_BR;
          w_pc_we  = zero;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_class.bne) begin
          w_pcs    = PCS_BR;
          w_pc_we  = ~zero;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_class.j) begin
          w_pcs    = PCS_JMP;
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_class.jr) begin
          w_pcs    = PCS_JR;
          w_pc_we  = 1'b1;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_class.rtype || w_class.addi) begin
          w_next = ST_WB;
        end else if (w_class.lw || w_class.sw) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_HALT;
        end
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_mem_wr  = w_class.sw;
        if (w_ready) begin
          if (w_class.sw) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        w_reg_we = 1'b1;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  // Enables are suppressed during reset so an abandoned access never leaks out.
  assign pc_source   = w_pcs;
  assign pc_we       = rst_n & w_pc_we;
  assign ir_we       = rst_n & w_ir_we;
  assign mem_req     = rst_n & w_mem_req;
  assign mem_wr      = rst_n & w_mem_wr;
  assign reg_we      = rst_n & w_reg_we;
  assign retire      = rst_n & w_retire;
  assign retired_cnt = r_cnt;
  assign halted      = r_halted;
  assign state       = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_FETCH;
      r_cnt    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == ST_HALT);
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Bench for pc_source_ctrl: per-cycle expected outputs are queued per
// instruction and compared at the falling edge; a 4-bit counter copy checks wrap.
module tb_pc_source_ctrl;
  import pc_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;

  logic [1:0]  pcSource, pcSource4;
  logic        pcWe, pcWe4, irWe, irWe4, memReq, memReq4, memWr, memWr4;
  logic        regWe, regWe4, retire, retire4, halted, halted4;
  logic [31:0] retiredCnt;
  logic [3:0]  retiredCnt4;
  logic [2:0]  state, state4;

  pc_source_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(memReady), .pc_source(pcSource), .pc_we(pcWe), .ir_we(irWe),
    .mem_req(memReq), .mem_wr(memWr), .reg_we(regWe), .retire(retire),
    .retired_cnt(retiredCnt), .halted(halted), .state(state)
  );

  pc_source_ctrl #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(memReady), .pc_source(pcSource4), .pc_we(pcWe4), .ir_we(irWe4),
    .mem_req(memReq4), .mem_wr(memWr4), .reg_we(regWe4), .retire(retire4),
    .retired_cnt(retiredCnt4), .halted(halted4), .state(state4)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] pcs;
    logic       pcWe;
    logic       irWe;
    logic       memReq;
    logic       memWr;
    logic       regWe;
    logic       retire;
    logic       halted;
  } obs_t;

  typedef struct packed {
    logic memReady;
    obs_t exp;
  } cyc_t;

  typedef enum logic [1:0] {K_CTRL, K_ALU, K_LOAD, K_STORE} kind_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    kind_t      kind;
    int         waits;
    logic [1:0] expPcs;
    logic       expPcWe;
    int         expLen;
  } vec_t;

  cyc_t sbQ[$];
  vec_t vecs[12];
  int   nVec   = 0;
  int   nMis   = 0;
  int   expCnt = 0;

  function automatic obs_t mk(state_t st, logic [1:0] pcs, logic pw, logic iw,
                              logic mr, logic mw, logic rw, logic rt, logic h);
    obs_t o;
    o = '{st: st, pcs: pcs, pcWe: pw, irWe: iw, memReq: mr, memWr: mw,
          regWe: rw, retire: rt, halted: h};
    return o;
  endfunction

  function automatic obs_t sampleObs();
    obs_t o;
    o = '{st: state, pcs: pcSource, pcWe: pcWe, irWe: irWe, memReq: memReq,
          memWr: memWr, regWe: regWe, retire: retire, halted: halted};
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t got, input obs_t want);
    nVec++;
    if (got !== want) begin
      nMis++;
      $display("[TB] FAIL %s: got %h want %h (st/pcs/pcwe/irwe/memreq/memwr/regwe/retire/halted)",
               name, got, want);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
    nVec++;
    if (got !== want) begin
      nMis++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push(input logic rdy, input obs_t e);
    cyc_t c;
    c.memReady = rdy;
    c.exp      = e;
    sbQ.push_back(c);
  endtask

  // Entered and left just after a rising edge.
  task automatic runQueue(input string name, output int retCyc);
    cyc_t e;
    obs_t got;
    int   cyc;
    cyc    = 0;
    retCyc = 0;
    while (sbQ.size() > 0) begin
      e        = sbQ.pop_front();
      memReady = e.memReady;
      @(negedge clk);
      cyc++;
      got = sampleObs();
      checkOutput($sformatf("%s_c%0d", name, cyc), got, e.exp);
      if (got.retire && retCyc == 0) retCyc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input string name);
    rst_n    = 1'b0;
    memReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput({name, "_forced"}, sampleObs(), mk(ST_FETCH, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    checkVal({name, "_cnt"}, retiredCnt, 0);
    checkVal({name, "_cnt4"}, {28'd0, retiredCnt4}, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    expCnt = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int   retCyc;
    logic isSt;
    isSt  = (v.kind == K_STORE);
    op    = v.op;
    funct = v.funct;
    zero  = v.zero;
    push(1'b1, mk(ST_FETCH,  PCS_SEQ, 1, 1, 1, 0, 0, 0, 0));
    push(1'b1, mk(ST_DECODE, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    if (v.kind == K_CTRL) begin
      push(1'b1, mk(ST_EXEC, v.expPcs, v.expPcWe, 0, 0, 0, 0, 1, 0));
    end else begin
      push(1'b1, mk(ST_EXEC, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
      if (v.kind != K_ALU) begin
        for (int i = 0; i < v.waits; i++)
          push(1'b0, mk(ST_MEM, PCS_SEQ, 0, 0, 1, isSt, 0, 0, 0));
        push(1'b1, mk(ST_MEM, PCS_SEQ, 0, 0, 1, isSt, 0, isSt, 0));
      end
      if (!isSt) push(1'b1, mk(ST_WB, PCS_SEQ, 0, 0, 0, 0, 1, 1, 0));
    end
    runQueue(v.name, retCyc);
    expCnt++;
    checkVal({v.name, "_latency"}, retCyc, v.expLen);
    checkVal({v.name, "_cnt"}, retiredCnt, expCnt);
    checkVal({v.name, "_cnt4"}, {28'd0, retiredCnt4}, expCnt % 16);
  endtask

  initial begin
    #1_000_000;
    nMis++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    int   retCyc;
    obs_t got;
    vecs[0]  = '{"beq_z1",  OP_BEQ,   6'h00,    1'b1, K_CTRL,  0, PCS_BR,  1'b1, 3};
    vecs[1]  = '{"beq_z0",  OP_BEQ,   6'h00,    1'b0, K_CTRL,  0, PCS_BR,  1'b0, 3};
    vecs[2]  = '{"bne_z1",  OP_BNE,   6'h00,    1'b1, K_CTRL,  0, PCS_BR,  1'b0, 3};
    vecs[3]  = '{"bne_z0",  OP_BNE,   6'h00,    1'b0, K_CTRL,  0, PCS_BR,  1'b1, 3};
    vecs[4]  = '{"j",       OP_J,     6'h00,    1'b0, K_CTRL,  0, PCS_JMP, 1'b1, 3};
    vecs[5]  = '{"jr",      OP_RTYPE, FUNCT_JR, 1'b0, K_CTRL,  0, PCS_JR,  1'b1, 3};
    vecs[6]  = '{"add",     OP_RTYPE, 6'h20,    1'b1, K_ALU,   0, PCS_SEQ, 1'b0, 4};
    vecs[7]  = '{"addi",    OP_ADDI,  6'h08,    1'b0, K_ALU,   0, PCS_SEQ, 1'b0, 4};
    vecs[8]  = '{"sw",      OP_SW,    6'h00,    1'b0, K_STORE, 0, PCS_SEQ, 1'b0, 4};
    vecs[9]  = '{"lw",      OP_LW,    6'h00,    1'b0, K_LOAD,  0, PCS_SEQ, 1'b0, 5};
    vecs[10] = '{"lw_wait3", OP_LW,   6'h00,    1'b0, K_LOAD,  3, PCS_SEQ, 1'b0, 8};
    vecs[11] = '{"sw_wait2", OP_SW,   6'h00,    1'b1, K_STORE, 2, PCS_SEQ, 1'b0, 6};

    op       = OP_BEQ;
    funct    = 6'h00;
    zero     = 1'b1;
    memReady = 1'b1;
    doReset("reset0");

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Illegal opcode: halts after DECODE and stays there with enables low.
    op    = 6'b111111;
    funct = 6'h00;
    push(1'b1, mk(ST_FETCH,  PCS_SEQ, 1, 1, 1, 0, 0, 0, 0));
    push(1'b1, mk(ST_DECODE, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) push(1'b1, mk(ST_HALT, PCS_SEQ, 0, 0, 0, 0, 0, 0, 1));
    runQueue("halt", retCyc);
    checkVal("halt_noretire", retCyc, 0);
    checkVal("halt_cnt", retiredCnt, expCnt);
    doReset("halt_exit");

    for (int i = 0; i < 16; i++) applyStimulus(vecs[4]);
    checkVal("wrap_cnt4", {28'd0, retiredCnt4}, 0);
    checkVal("wrap_cnt32", retiredCnt, 16);

    // Reset arriving while a store waits in MEM.
    op    = OP_SW;
    funct = 6'h00;
    push(1'b1, mk(ST_FETCH,  PCS_SEQ, 1, 1, 1, 0, 0, 0, 0));
    push(1'b1, mk(ST_DECODE, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, mk(ST_EXEC,   PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, mk(ST_MEM,    PCS_SEQ, 0, 0, 1, 1, 0, 0, 0));
    runQueue("sw_rst", retCyc);
    memReady = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    got = sampleObs();
    checkOutput("sw_rst_wait", got, mk(ST_MEM, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    memReady = 1'b1;
    #1;
    got = sampleObs();
    checkOutput("sw_rst_ready", got, mk(ST_MEM, PCS_SEQ, 0, 0, 0, 0, 0, 0, 0));
    checkVal("sw_rst_retire4", {31'd0, retire4}, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    expCnt = 0;
    checkVal("sw_rst_state", {29'd0, state}, 0);
    checkVal("sw_rst_cnt", retiredCnt, 0);
    applyStimulus(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
